// File: rtl/acc_cpu_core_if.sv
// Control/load/IO bundle between the accumulator core and its pin wrapper or bench.
// run and ld_en are single-cycle strobes with no ready line: halted acts as the ready, and both are accepted only while halted=1.
interface acc_cpu_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int SP_W   = 4
);
  logic              run;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] io_in;
  logic [DATA_W-1:0] io_out;
  logic              io_strobe;
  logic              halted;
  logic              fault;
  logic [ADDR_W-1:0] pc_dbg;
  logic [1:0]        state_dbg;
  logic [SP_W-1:0]   sp_dbg;
  logic [DATA_W-1:0] acc_dbg;
  logic              z_dbg;
  logic              c_dbg;

  modport master (
    output run, ld_en, ld_addr, ld_data, io_in,
    input  io_out, io_strobe, halted, fault, pc_dbg,
    input  state_dbg, sp_dbg, acc_dbg, z_dbg, c_dbg
  );

  modport slave (
    input  run, ld_en, ld_addr, ld_data, io_in,
    output io_out, io_strobe, halted, fault, pc_dbg,
    output state_dbg, sp_dbg, acc_dbg, z_dbg, c_dbg
  );
endinterface

// File: rtl/acc_cpu_core.sv
// Parametrised accumulator CPU: HALT/FETCH/EXEC machine, unified RAM, hardware stack,
// Z/C flags and a program-load port that is live only while halted.
module acc_cpu_core #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  acc_cpu_core_if.slave bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int MEM_D = 1 << ADDR_W;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [1:0] {S_HALT = 2'd0, S_FETCH = 2'd1, S_EXEC = 2'd2} state_t;

  localparam logic [3:0] OP_LOAD = 4'h1, OP_STORE = 4'h2, OP_ADD = 4'h3, OP_LDI = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5, OP_PUSH  = 4'h6, OP_POP = 4'h7, OP_JMP = 4'h8;
  localparam logic [3:0] OP_OUT  = 4'h9, OP_IN    = 4'hA, OP_JZ  = 4'hB, OP_JC  = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD, OP_RET   = 4'hE, OP_HLT = 4'hF;

  logic [DATA_W-1:0] mem   [MEM_D];
  logic [DATA_W-1:0] stack [STACK_DEPTH];

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt;
  logic [DATA_W-1:0]   acc, acc_nxt;
  logic [ADDR_W+3:0]   ir, ir_nxt;
  logic [SP_W-1:0]     sp, sp_nxt;
  logic                z, z_nxt, c, c_nxt;
  logic [DATA_W-1:0]   io_out, io_out_nxt;
  logic                io_strobe, strobe_nxt;
  logic                fault, fault_nxt;

  logic                mem_we, stk_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata, stk_wdata;

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   opa;
  logic [DATA_W-1:0]   opnd, opa_ext, stk_rd;
  logic [DATA_W:0]     sum, diff;
  logic [SP_W-1:0]     sp_dec;
  logic [IDX_W-1:0]    push_idx, pop_idx;

  assign opcode   = ir[ADDR_W+3:ADDR_W];
  assign opa      = ir[ADDR_W-1:0];
  assign opnd     = mem[opa];
  assign opa_ext  = {{(DATA_W-ADDR_W){1'b0}}, opa};
  assign sum      = {1'b0, acc} + {1'b0, opnd};
  // Top bit of the extended difference is the unsigned borrow.
  assign diff     = {1'b0, acc} - {1'b0, opnd};
  assign sp_dec   = sp - SP_W'(1);
  assign push_idx = sp[IDX_W-1:0];
  assign pop_idx  = sp_dec[IDX_W-1:0];
  assign stk_rd   = stack[pop_idx];

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    acc_nxt    = acc;
    ir_nxt     = ir;
    sp_nxt     = sp;
    z_nxt      = z;
    c_nxt      = c;
    io_out_nxt = io_out;
    strobe_nxt = 1'b0;
    fault_nxt  = fault;
    mem_we     = 1'b0;
    mem_waddr  = bus.ld_addr;
    mem_wdata  = bus.ld_data;
    stk_we     = 1'b0;
    stk_wdata  = acc;
    unique case (state)
      S_HALT: begin
        mem_we = bus.ld_en;
        if (bus.run && !fault) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        ir_nxt    = mem[pc][ADDR_W+3:0];
        pc_nxt    = pc + ADDR_W'(1);
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        unique case (opcode)
          OP_LOAD:  begin acc_nxt = opnd; z_nxt = (opnd == '0); end
          OP_STORE: begin mem_we = 1'b1; mem_waddr = opa; mem_wdata = acc; end
          OP_ADD:   begin acc_nxt = sum[DATA_W-1:0]; c_nxt = sum[DATA_W]; z_nxt = (sum[DATA_W-1:0] == '0); end
          OP_LDI:   begin acc_nxt = opa_ext; z_nxt = (opa == '0); end
          OP_SUB:   begin acc_nxt = diff[DATA_W-1:0]; c_nxt = diff[DATA_W]; z_nxt = (diff[DATA_W-1:0] == '0); end
          OP_JMP:   pc_nxt = opa;
          OP_OUT:   begin io_out_nxt = acc; strobe_nxt = 1'b1; end
          OP_IN:    begin acc_nxt = bus.io_in; z_nxt = (bus.io_in == '0); end
          OP_JZ:    if (z) pc_nxt = opa;
          OP_JC:    if (c) pc_nxt = opa;
          OP_HLT:   state_nxt = S_HALT;
          OP_PUSH, OP_CALL: begin
            if (sp == SP_FULL) begin
              fault_nxt = 1'b1;
              state_nxt = S_HALT;
            end else begin
              stk_we = 1'b1;
              sp_nxt = sp + SP_W'(1);
              // pc already holds the return address, bumped during FETCH.
              if (opcode == OP_CALL) begin
                stk_wdata = {{(DATA_W-ADDR_W){1'b0}}, pc};
                pc_nxt    = opa;
              end
            end
          end
          OP_POP, OP_RET: begin
            if (sp == '0) begin
              fault_nxt = 1'b1;
              state_nxt = S_HALT;
            end else begin
              sp_nxt = sp_dec;
              if (opcode == OP_POP) begin
                acc_nxt = stk_rd;
                z_nxt   = (stk_rd == '0);
              end else begin
                pc_nxt = stk_rd[ADDR_W-1:0];
              end
            end
          end
          default: ;
        endcase
      end
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_HALT;
      pc        <= '0;
      acc       <= '0;
      ir        <= '0;
      sp        <= '0;
      z         <= 1'b0;
      c         <= 1'b0;
      io_out    <= '0;
      io_strobe <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      acc       <= acc_nxt;
      ir        <= ir_nxt;
      sp        <= sp_nxt;
      z         <= z_nxt;
      c         <= c_nxt;
      io_out    <= io_out_nxt;
      io_strobe <= strobe_nxt;
      fault     <= fault_nxt;
    end
  end

  // Storage is not cleared by reset, but a reset edge must still suppress any write.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_waddr] <= mem_wdata;
    if (rst_n && stk_we) stack[push_idx] <= stk_wdata;
  end

  assign bus.io_out    = io_out;
  assign bus.io_strobe = io_strobe;
  assign bus.halted    = (state == S_HALT);
  assign bus.fault     = fault;
  assign bus.pc_dbg    = pc;
  assign bus.state_dbg = state;
  assign bus.sp_dbg    = sp;
  assign bus.acc_dbg   = acc;
  assign bus.z_dbg     = z;
  assign bus.c_dbg     = c;
endmodule
